piezo_echo_detector: RTL and testbench

//  Front end of the piezo receive path. Qualifies the raw asynchronous echo-comparator input,

---
 rtl/piezo_pkg.sv | 17 +
 rtl/ts_fifo.sv | 49 ++++
 rtl/piezo_echo_detector.sv | 142 ++++++++++++++
 tb/tb_piezo_echo_detector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared types for the piezo echo receive path.
package piezo_pkg;

  localparam int unsigned TS_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK   = 3'd1,
    ARMED   = 3'd2,
    HOLDOFF = 3'd3
  } det_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// First-word fall-through timestamp buffer; a push into a full FIFO with no pop is dropped
// and flagged on o_drop.
module ts_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && !w_push;
  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/piezo_echo_detector.sv
// Piezo receive front end: synchronise and filter the echo comparator, blank around our own
// transmit burst, pulse event_trigger per accepted echo and buffer its rise timestamp.
module piezo_echo_detector
  import piezo_pkg::*;
#(
  parameter int unsigned TS_WIDTH       = TS_WIDTH_DEF,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned BLANK_CYCLES   = 5000,
  parameter int unsigned HOLDOFF_CYCLES = 20000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [TS_WIDTH-1:0] i_time_now,
  input  logic                i_piezo_enable,
  input  logic                i_echo_in,
  output logic                o_event_trigger,
  output logic [TS_WIDTH-1:0] o_ts_data,
  output logic                o_ts_valid,
  input  logic                i_ts_ready,
  output logic [7:0]          o_overflow_cnt,
  output logic [2:0]          o_det_state
);
  localparam int unsigned RunW   = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned CntMax = (BLANK_CYCLES > HOLDOFF_CYCLES) ? BLANK_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic                r_sync1;
  logic                r_echo_s;
  logic [RunW-1:0]     r_run;
  logic                r_blocked;
  logic [TS_WIDTH-1:0] r_t_rise;
  det_state_t          r_state;
  det_state_t          w_state_d;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_d;
  logic                r_trigger;
  logic [7:0]          r_ovf;
  logic                w_push;
  logic                w_drop;
  logic                w_qualify;
  logic [TS_WIDTH-1:0] w_t_rise;

  // Bypass so the rise time is available even when FILTER_CYCLES=1 qualifies on the rise cycle.
  assign w_t_rise  = (r_echo_s && r_run == '0) ? i_time_now : r_t_rise;
  // Run counter saturates at FILTER_CYCLES, so the equality fires once per high run.
  assign w_qualify = r_echo_s && !r_blocked && (r_run == RunW'(FILTER_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_echo_s  <= 1'b0;
      r_run     <= '0;
      r_blocked <= 1'b0;
      r_t_rise  <= '0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_trigger <= 1'b0;
      r_ovf     <= '0;
    end else begin
      r_sync1   <= i_echo_in;
      r_echo_s  <= r_sync1;
      if (!r_echo_s)                           r_run <= '0;
      else if (r_run != RunW'(FILTER_CYCLES))  r_run <= r_run + 1'b1;
      // A run that overlaps blanking stays disqualified until echo_s drops.
      r_blocked <= r_echo_s && (r_blocked || r_state == BLANK);
      r_t_rise  <= w_t_rise;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_trigger <= w_push;
      if (w_drop) r_ovf <= sat_inc8(r_ovf);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_push    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_piezo_enable) begin
          w_state_d = BLANK;
          w_cnt_d   = '0;
        end
      end
      BLANK: begin
        if (i_piezo_enable) begin
          w_cnt_d = '0;
        end else if (r_cnt == CntW'(BLANK_CYCLES - 1)) begin
          w_state_d = ARMED;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      ARMED: begin
        if (i_piezo_enable) begin
          w_state_d = BLANK;
          w_cnt_d   = '0;
        end else if (w_qualify) begin
          w_push    = 1'b1;
          w_state_d = HOLDOFF;
          w_cnt_d   = '0;
        end
      end
      HOLDOFF: begin
        if (i_piezo_enable) begin
          w_state_d = BLANK;
          w_cnt_d   = '0;
        end else if (r_cnt == CntW'(HOLDOFF_CYCLES - 1)) begin
          w_state_d = ARMED;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  ts_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_t_rise),
    .i_pop   (i_ts_ready),
    .o_data  (o_ts_data),
    .o_valid (o_ts_valid),
    .o_drop  (w_drop)
  );

  assign o_event_trigger = r_trigger;
  assign o_overflow_cnt  = r_ovf;
  assign o_det_state     = r_state;

endmodule

// File: tb/tb_piezo_echo_detector.sv
// Directed and randomised bench for piezo_echo_detector against a cycle-stepped reference model.
module tb_piezo_echo_detector;
  localparam int unsigned FC    = 4;
  localparam int unsigned BC    = 10;
  localparam int unsigned HC    = 50;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tn;
  logic        en;
  logic        echo;
  logic        ready;
  logic        o_event_trigger;
  logic [31:0] o_ts_data;
  logic        o_ts_valid;
  logic [7:0]  o_overflow_cnt;
  logic [2:0]  o_det_state;

  int checks   = 0;
  int failures = 0;
  int n_dut_trig = 0;

  always #5 clk = ~clk;

  piezo_echo_detector #(
    .TS_WIDTH       (32),
    .FILTER_CYCLES  (FC),
    .BLANK_CYCLES   (BC),
    .HOLDOFF_CYCLES (HC),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_time_now      (tn),
    .i_piezo_enable  (en),
    .i_echo_in       (echo),
    .o_event_trigger (o_event_trigger),
    .o_ts_data       (o_ts_data),
    .o_ts_valid      (o_ts_valid),
    .i_ts_ready      (ready),
    .o_overflow_cnt  (o_overflow_cnt),
    .o_det_state     (o_det_state)
  );

  // Reference model: phase 0=idle 1=blank 2=armed 3=holdoff, m_left = dead cycles remaining.
  int          m_phase, m_left, m_runlen, m_ovf;
  bit          m_taint, m_trig, m_d1, m_d2;
  logic [31:0] m_rise;
  logic [31:0] m_q[$];

  task automatic model_step();
    bit es, qual, pop, push;
    if (reset) begin
      m_phase = 0; m_left = 0; m_runlen = 0; m_ovf = 0;
      m_taint = 0; m_trig = 0; m_d1 = 0; m_d2 = 0;
      m_q.delete();
      return;
    end
    es   = m_d2;
    m_d2 = m_d1;
    m_d1 = echo;
    if (es) begin
      m_runlen++;
      if (m_runlen == 1) begin
        m_rise  = tn;
        m_taint = 0;
      end
    end else begin
      m_runlen = 0;
    end
    if (es && m_phase == 1) m_taint = 1;
    qual = es && !m_taint && (m_runlen == FC);
    pop  = ready && (m_q.size() > 0);
    push = 0;
    if (en) begin
      m_phase = 1;
      m_left  = BC;
    end else begin
      case (m_phase)
        1, 3: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        2: if (qual) begin
          push    = 1;
          m_phase = 3;
          m_left  = HC;
        end
        default: ;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_rise);
      else if (m_ovf < 255)   m_ovf++;
    end
    m_trig = push;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (o_event_trigger === 1'b1) n_dut_trig++;
    chk("trigger", 32'(o_event_trigger), 32'(m_trig));
    chk("ts_valid", 32'(o_ts_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("ts_data", o_ts_data, m_q[0]);
    chk("overflow_cnt", 32'(o_overflow_cnt), 32'(m_ovf));
    chk("det_state", 32'(o_det_state), 32'(m_phase));
    tn = tn + 32'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pop1();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // Echo high for `hi` cycles then low for `lo` cycles.
  task automatic hit(input int hi, input int lo);
    echo = 1'b1;
    run(hi);
    echo = 1'b0;
    run(lo);
  endtask

  initial begin
    logic [31:0] t_a, t_b;
    int base;
    int echo_left, en_left;
    reset = 1'b1; en = 1'b0; echo = 1'b0; ready = 1'b0; tn = $urandom;

    // 1: reset and idle
    run(3);
    chk("rst_state", 32'(o_det_state), 32'd0);
    chk("rst_valid", 32'(o_ts_valid), 32'd0);
    chk("rst_ovf", 32'(o_overflow_cnt), 32'd0);
    chk("rst_data", o_ts_data, 32'd0);
    reset = 1'b0;
    base = n_dut_trig;
    for (int i = 0; i < 4; i++) hit(8, $urandom_range(2, 10));
    chk("idle_no_trig", 32'(n_dut_trig - base), 32'd0);
    chk("idle_state", 32'(o_det_state), 32'd0);

    // 2: burst then echo 15 cycles after the fall
    en = 1'b1;
    run(20);
    en = 1'b0;
    run(14);
    base = n_dut_trig;
    tn = 32'h0000_00FE;
    hit(8, 5);
    chk("burst_trig", 32'(n_dut_trig - base), 32'd1);
    chk("burst_ts", o_ts_data, 32'h0000_0100);
    pop1();
    chk("burst_empty", 32'(o_ts_valid), 32'd0);

    // 3: glitch while armed, and echo held from blank into armed
    run(50);
    chk("armed", 32'(o_det_state), 32'd2);
    base = n_dut_trig;
    hit(3, 10);
    en = 1'b1;
    run(3);
    en = 1'b0;
    hit(20, 5);
    chk("glitch_blank_no_trig", 32'(n_dut_trig - base), 32'd0);
    chk("rearmed", 32'(o_det_state), 32'd2);

    // 4: holdoff
    base = n_dut_trig;
    hit(6, 24);
    hit(6, 60);
    chk("holdoff_30", 32'(n_dut_trig - base), 32'd1);
    ready = 1'b1; run(2); ready = 1'b0;
    base = n_dut_trig;
    hit(6, 54);
    hit(6, 10);
    chk("holdoff_60", 32'(n_dut_trig - base), 32'd2);
    t_a = o_ts_data;
    pop1();
    t_b = o_ts_data;
    chk("ts_order_gap", t_b - t_a, 32'd60);
    pop1();
    chk("holdoff_drained", 32'(o_ts_valid), 32'd0);

    // 5: overflow
    run(60);
    base = n_dut_trig;
    for (int i = 0; i < 6; i++) hit(6, 64);
    chk("ovf_trigs", 32'(n_dut_trig - base), 32'd6);
    chk("ovf_cnt", 32'(o_overflow_cnt), 32'd2);

    // 6a: push and pop in the same cycle while full
    echo = 1'b1;
    run(5);
    ready = 1'b1;
    step();
    ready = 1'b0;
    echo = 1'b0;
    chk("fullpp_trig", 32'(o_event_trigger), 32'd1);
    run(64);
    chk("fullpp_ovf", 32'(o_overflow_cnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("full_entry_valid", 32'(o_ts_valid), 32'd1);
      pop1();
    end
    chk("full_four_entries", 32'(o_ts_valid), 32'd0);

    // 6b: time_now wrap, stored raw
    tn = 32'hFFFF_FFFC;
    hit(6, 2);
    chk("wrap_ts", o_ts_data, 32'hFFFF_FFFE);
    run(62);
    tn = 32'hFFFF_FFFF;
    hit(6, 10);
    chk("holdoff_before_rst", 32'(o_det_state), 32'd3);

    // 6c: reset in holdoff with two entries queued
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_valid", 32'(o_ts_valid), 32'd0);
    chk("rst_mid_state", 32'(o_det_state), 32'd0);

    // Randomised traffic
    echo_left = 0;
    en_left   = 0;
    for (int c = 0; c < 4000; c++) begin
      if (echo_left == 0) begin
        echo = ~echo;
        echo_left = echo ? $urandom_range(1, 8) : $urandom_range(1, 40);
      end
      echo_left--;
      if (en_left > 0) begin
        en = 1'b1;
        en_left--;
      end else begin
        en = 1'b0;
        if ($urandom_range(0, 149) == 0) en_left = $urandom_range(1, 10);
      end
      ready = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
